// File: rtl/alu_pkg.sv
// Shared ALU definitions: the add/sub sequencer state encoding, the compare
// stage function codes, and the Z/V/N flag derivation used at completion.
package alu_pkg;

    // Sequencer states of the multi-cycle adder/subtractor.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Compare-stage function codes; the comparator consumes Z/V/N under these.
    typedef enum logic [2:0] {
        ALUFUN_NE  = 3'b000,
        ALUFUN_EQ  = 3'b001,
        ALUFUN_LT  = 3'b010,
        ALUFUN_LTZ = 3'b101,
        ALUFUN_LEZ = 3'b110,
        ALUFUN_GTZ = 3'b111
    } alufun_t;

    // Flag bundle registered together with the result.
    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flags_t;

    // Derive Z/V/N from the finished result.  bx_msb is the MSB of the
    // (possibly inverted) B operand actually fed to the adder, so signed
    // overflow uses the same rule for add and subtract.  For unsigned
    // subtract the final carry-out is the inverse of the borrow.
    function automatic flags_t calc_flags(
        input logic is_zero,
        input logic s_msb,
        input logic a_msb,
        input logic bx_msb,
        input logic cout,
        input logic sign,
        input logic sub
    );
        flags_t f;
        f.z = is_zero;
        if (sign) begin
            f.v = (a_msb == bx_msb) & (s_msb != a_msb);
            f.n = s_msb;
        end else if (sub) begin
            f.v = 1'b0;
            f.n = ~cout;
        end else begin
            f.v = cout;
            f.n = 1'b0;
        end
        return f;
    endfunction

endpackage

// File: rtl/alu_chunk_adder.sv
// CHUNK-bit combinational adder slice; the sequencer reuses one instance
// every cycle, feeding it one operand chunk plus the registered carry.
module alu_chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] total_s;

    // Full-width add with one extra bit to capture the chunk carry-out.
    always_comb begin
        total_s = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        sum     = total_s[CHUNK-1:0];
        cout    = total_s[CHUNK];
    end

endmodule

// File: rtl/alu_addsub_seq.sv
// Multi-cycle adder/subtractor: WIDTH-bit A+B or A-B computed CHUNK bits per
// cycle through a registered ripple carry, producing S and Z/V/N flags for
// the compare stage.  WIDTH must be a multiple of CHUNK.
// Optional feature: define ALU_ADDSUB_ABORT_EN to add the abort input, which
// cancels a running operation without producing done or touching S/flags.
module alu_addsub_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    input  logic             Sign,
`ifdef ALU_ADDSUB_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Z,
    output logic             V,
    output logic             N
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    // Sequencer state and control decoded from it.
    state_t          state_r;
    state_t          state_nx_s;
    logic            load_s;
    logic            step_s;
    logic            finish_s;
    logic            abort_s;
    logic            last_s;

    // Latched operation context.
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] bx_r;
    logic             carry_r;
    logic             sub_r;
    logic             sign_r;
    logic [IW-1:0]    idx_r;
    logic [WIDTH-1:0] res_r;

    // Chunk adder interface and assembled final result.
    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK-1:0] sum_s;
    logic             cout_s;
    logic [WIDTH-1:0] full_s;
    flags_t           flags_s;

    // Registered outputs.
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] s_r;
    logic             z_r;
    logic             v_r;
    logic             n_r;

`ifdef ALU_ADDSUB_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign last_s = (idx_r == IW'(NCH - 1));

    // Select the operand chunk addressed by the current index.
    always_comb begin
        a_chunk_s = a_r[idx_r*CHUNK +: CHUNK];
        b_chunk_s = bx_r[idx_r*CHUNK +: CHUNK];
    end

    alu_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (a_chunk_s),
        .b    (b_chunk_s),
        .cin  (carry_r),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // Merge the chunk being computed this cycle into the partial result so
    // the last cycle can register S and flags without an extra stage.
    always_comb begin
        full_s                          = res_r;
        full_s[idx_r*CHUNK +: CHUNK]    = sum_s;
        flags_s = calc_flags((full_s == {WIDTH{1'b0}}), full_s[WIDTH-1],
                             a_r[WIDTH-1], bx_r[WIDTH-1], cout_s,
                             sign_r, sub_r);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and control decode; abort wins over completion.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        step_s     = 1'b0;
        finish_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s     = 1'b1;
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (abort_s) begin
                    state_nx_s = IDLE;
                end else begin
                    step_s = 1'b1;
                    if (last_s) begin
                        finish_s   = 1'b1;
                        state_nx_s = IDLE;
                    end else begin
                        state_nx_s = RUN;
                    end
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Operand latch, ripple-carry chain and partial-result accumulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r     <= {WIDTH{1'b0}};
            bx_r    <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            sub_r   <= 1'b0;
            sign_r  <= 1'b0;
            idx_r   <= {IW{1'b0}};
            res_r   <= {WIDTH{1'b0}};
        end else if (load_s) begin
            a_r     <= A;
            bx_r    <= Sub ? ~B : B;
            carry_r <= Sub;
            sub_r   <= Sub;
            sign_r  <= Sign;
            idx_r   <= {IW{1'b0}};
        end else if (step_s) begin
            res_r[idx_r*CHUNK +: CHUNK] <= sum_s;
            carry_r                     <= cout_s;
            idx_r                       <= idx_r + IW'(1);
        end
    end

    // Output registers: busy follows the next state, done pulses on the
    // completing edge, and S/flags hold until the next completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            s_r    <= {WIDTH{1'b0}};
            z_r    <= 1'b0;
            v_r    <= 1'b0;
            n_r    <= 1'b0;
        end else begin
            busy_r <= (state_nx_s == RUN);
            done_r <= finish_s;
            if (finish_s) begin
                s_r <= full_s;
                z_r <= flags_s.z;
                v_r <= flags_s.v;
                n_r <= flags_s.n;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign S    = s_r;
    assign Z    = z_r;
    assign V    = v_r;
    assign N    = n_r;

endmodule

// File: tb/tb_alu_addsub_seq.sv
// Directed bench for alu_addsub_seq (WIDTH=32, CHUNK=8, latency 4 cycles).
// Covers ALU_ADDSUB_ABORT_EN when that macro is defined.
module tb_alu_addsub_seq;

    localparam int NCH = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        Sub;
    logic        Sign;
    logic        busy;
    logic        done;
    logic [31:0] S;
    logic        Z;
    logic        V;
    logic        N;
`ifdef ALU_ADDSUB_ABORT_EN
    logic        abort;
`endif

    int total;
    int bad;

    alu_addsub_seq #(
        .WIDTH (32),
        .CHUNK (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .Sub   (Sub),
        .Sign  (Sign),
`ifdef ALU_ADDSUB_ABORT_EN
        .abort (abort),
`endif
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Z     (Z),
        .V     (V),
        .N     (N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation with cycle-exact done/busy checks and result checks.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic sign, input logic [31:0] exp_s,
                          input logic ez, input logic ev, input logic en);
        A = a; B = b; Sub = sub; Sign = sign; start = 1'b1;
        tick();
        start = 1'b0;
        A = 32'hDEAD_BEEF; B = 32'h1234_5678; Sub = ~sub;
        chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
        for (int i = 1; i < NCH; i++) begin
            tick();
            chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
        end
        tick();
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busyend"}, {31'd0, busy}, 32'd0);
        chk({tag, "_S"}, S, exp_s);
        chk({tag, "_Z"}, {31'd0, Z}, {31'd0, ez});
        chk({tag, "_V"}, {31'd0, V}, {31'd0, ev});
        chk({tag, "_N"}, {31'd0, N}, {31'd0, en});
        tick();
        chk({tag, "_doneoff"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        start = 1'b0;
        A = 32'd0; B = 32'd0; Sub = 1'b0; Sign = 1'b0;
`ifdef ALU_ADDSUB_ABORT_EN
        abort = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_S", S, 32'd0);
        chk("rst_flags", {29'd0, Z, V, N}, 32'd0);

        run_op("sadd_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        run_op("ssub_eq", 32'd5, 32'd5, 1'b1, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
        run_op("uadd_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        run_op("ssub_neg", 32'h8000_0000, 32'd1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_op("uadd_mix", 32'h1234_5678, 32'h0F0F_F0F0, 1'b0, 1'b0, 32'h2144_4768, 1'b0, 1'b0, 1'b0);
        run_op("usub_lt", 32'd3, 32'd5, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);

        // Reset during RUN of 5+3: outputs clear at once, no done afterwards.
        A = 32'd5; B = 32'd3; Sub = 1'b0; Sign = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_S", S, 32'd0);
        chk("midrst_flags", {29'd0, Z, V, N}, 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_nodone", {30'd0, busy, done}, 32'd0);
        end

        // start pulse while busy with other operands must be ignored.
        A = 32'd100; B = 32'd50; Sub = 1'b1; Sign = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        A = 32'd1; B = 32'd1; Sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("ign_done", {31'd0, done}, 32'd1);
        chk("ign_S", S, 32'd50);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("ign_nodone", {31'd0, done}, 32'd0);
        end

        // start held high: accepts at relative edges 0,5,10,15, done at 4,9,14,19.
        Sign = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if ((k % 2) == 0) begin
                A = 32'd10; B = 32'd20; Sub = 1'b0;
            end else begin
                A = 32'd100; B = 32'd1; Sub = 1'b1;
            end
            tick();
            chk("b2b_done", {31'd0, done}, ((k % 5) == 4) ? 32'd1 : 32'd0);
            if ((k % 5) == 4) begin
                chk("b2b_S", S, (((k - 4) % 10) == 0) ? 32'd30 : 32'd99);
            end
        end
        start = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b2b_idle", {30'd0, busy, done}, 32'd0);
        end

`ifdef ALU_ADDSUB_ABORT_EN
        run_op("pre_abort", 32'd7, 32'd9, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        A = 32'd1; B = 32'd1; Sub = 1'b0; Sign = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("abort_nodone", {31'd0, done}, 32'd0);
        end
        chk("abort_S", S, 32'hFFFF_FFFE);
        chk("abort_flags", {29'd0, Z, V, N}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        run_op("post_abort", 32'd40, 32'd2, 1'b0, 1'b0, 32'd42, 1'b0, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
